// File: rtl/led_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | led_sequencer : programmable multi-step LED blink scheduler              |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module led_sequencer #(
  parameter int          NUM_LEDS = 4,
  parameter int unsigned PRESCALE = 5_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [2:0]          cmd_addr,
  input  logic [NUM_LEDS-1:0] cmd_pattern,
  input  logic [7:0]          cmd_arg,
  input  logic                stop,
  output logic [NUM_LEDS-1:0] led,
  output logic                busy,
  output logic [2:0]          step,
  output logic                done
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [1:0]  OP_WRITE   = 2'b00;
  localparam logic [1:0]  OP_START   = 2'b01;
  localparam logic [31:0] PRESC_LAST = 32'(PRESCALE - 1);

  state_t              state_q, state_d;
  logic [NUM_LEDS-1:0] mem_pat_q [8];
  logic [NUM_LEDS-1:0] mem_pat_d [8];
  logic [7:0]          mem_dur_q [8];
  logic [7:0]          mem_dur_d [8];
  logic [2:0]          last_q, last_d;
  logic [7:0]          loops_q, loops_d;
  logic                inf_q, inf_d;
  logic [2:0]          step_q, step_d;
  logic [NUM_LEDS-1:0] led_q, led_d;
  logic                done_q, done_d;
  logic [31:0]         presc_q, presc_d;
  logic [7:0]          tick_q, tick_d;

  logic [2:0] next_step;
  logic [7:0] cur_dur;
  logic [7:0] tick_last;
  logic       presc_tc;
  logic       step_end;

  assign next_step = step_q + 3'd1;
  assign cur_dur   = mem_dur_q[step_q];
  // A zero duration still holds the step for one tick.
  assign tick_last = (cur_dur == 8'd0) ? 8'd0 : cur_dur - 8'd1;
  assign presc_tc  = (presc_q == PRESC_LAST);
  assign step_end  = presc_tc && (tick_q == tick_last);

  always_comb begin
    state_d   = state_q;
    mem_pat_d = mem_pat_q;
    mem_dur_d = mem_dur_q;
    last_d    = last_q;
    loops_d   = loops_q;
    inf_d     = inf_q;
    step_d    = step_q;
    led_d     = led_q;
    done_d    = 1'b0;
    presc_d   = presc_q;
    tick_d    = tick_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_op == OP_WRITE) begin
            mem_pat_d[cmd_addr] = cmd_pattern;
            mem_dur_d[cmd_addr] = cmd_arg;
          end else if (cmd_op == OP_START) begin
            last_d  = cmd_addr;
            loops_d = cmd_arg;
            inf_d   = (cmd_arg == 8'd0);
            state_d = RUN;
            step_d  = 3'd0;
            led_d   = mem_pat_q[0];
            presc_d = 32'd0;
            tick_d  = 8'd0;
          end
        end
      end
      RUN: begin
        // stop outranks any step or loop boundary in the same cycle
        if (stop) begin
          state_d = IDLE;
          led_d   = '0;
          step_d  = 3'd0;
          presc_d = 32'd0;
          tick_d  = 8'd0;
        end else if (step_end) begin
          presc_d = 32'd0;
          tick_d  = 8'd0;
          if (step_q != last_q) begin
            step_d = next_step;
            led_d  = mem_pat_q[next_step];
          end else if (inf_q || (loops_q != 8'd1)) begin
            if (!inf_q) begin
              loops_d = loops_q - 8'd1;
            end
            step_d = 3'd0;
            led_d  = mem_pat_q[0];
          end else begin
            loops_d = 8'd0;
            state_d = IDLE;
            step_d  = 3'd0;
            led_d   = '0;
            done_d  = 1'b1;
          end
        end else if (presc_tc) begin
          presc_d = 32'd0;
          tick_d  = tick_q + 8'd1;
        end else begin
          presc_d = presc_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      for (int i = 0; i < 8; i++) begin
        mem_pat_q[i] <= '0;
        mem_dur_q[i] <= 8'd0;
      end
      last_q  <= 3'd0;
      loops_q <= 8'd0;
      inf_q   <= 1'b0;
      step_q  <= 3'd0;
      led_q   <= '0;
      done_q  <= 1'b0;
      presc_q <= 32'd0;
      tick_q  <= 8'd0;
    end else begin
      state_q   <= state_d;
      mem_pat_q <= mem_pat_d;
      mem_dur_q <= mem_dur_d;
      last_q    <= last_d;
      loops_q   <= loops_d;
      inf_q     <= inf_d;
      step_q    <= step_d;
      led_q     <= led_d;
      done_q    <= done_d;
      presc_q   <= presc_d;
      tick_q    <= tick_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign led       = led_q;
  assign step      = step_q;
  assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_led_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_led_sequencer : playback checks against a cycle-trace reference model |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_led_sequencer;
  localparam int NL = 4;
  localparam int P  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [2:0]    cmd_addr = 3'd0;
  logic [NL-1:0] cmd_pattern = '0;
  logic [7:0]    cmd_arg = 8'd0;
  logic          stop = 1'b0;
  logic [NL-1:0] led;
  logic          busy;
  logic [2:0]    step;
  logic          done;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: step table as the host has written it, and the expected
  // per-cycle display trace of a playback derived from it.
  logic [NL-1:0] m_pat [8];
  logic [7:0]    m_dur [8];
  logic [NL-1:0] exp_led [$];
  logic [2:0]    exp_step [$];

  always #5 clk = ~clk;

  led_sequencer #(.NUM_LEDS(NL), .PRESCALE(P)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_pattern(cmd_pattern),
    .cmd_arg(cmd_arg), .stop(stop), .led(led), .busy(busy), .step(step),
    .done(done)
  );

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 8; i++) begin
      m_pat[i] = '0;
      m_dur[i] = 8'd0;
    end
  endfunction

  function automatic void model_play(int last, int loops);
    exp_led.delete();
    exp_step.delete();
    for (int l = 0; l < loops; l++)
      for (int s = 0; s <= last; s++) begin
        int eff;
        eff = (m_dur[s] == 8'd0) ? 1 : int'(m_dur[s]);
        for (int c = 0; c < eff * P; c++) begin
          exp_led.push_back(m_pat[s]);
          exp_step.push_back(3'(s));
        end
      end
  endfunction

  // Presents one command and returns just after the edge that accepts it.
  task automatic issue(input logic [1:0] op, input logic [2:0] addr,
                       input logic [NL-1:0] pat, input logic [7:0] arg);
    int waited;
    waited      = 0;
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_addr    = addr;
    cmd_pattern = pat;
    cmd_arg     = arg;
    while (cmd_ready !== 1'b1 && waited < 500) begin
      tick();
      waited++;
    end
    n_checks++;
    if (waited >= 500) begin
      n_fail++;
      $display("FAIL cmd_accept: cmd_ready=%b after %0d cycles, required 1", cmd_ready, waited);
    end
    tick();
    cmd_valid = 1'b0;
    if (op == 2'b00) begin
      m_pat[addr] = pat;
      m_dur[addr] = arg;
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_checks++;
    if ({led, busy, done, cmd_ready, step} !== {4'h0, 1'b0, 1'b0, 1'b1, 3'd0}) begin
      n_fail++;
      $display("FAIL reset_hold: led=%h busy=%b done=%b rdy=%b step=%0d, required 0 0 0 1 0",
               led, busy, done, cmd_ready, step);
    end
    #2 rst = 1'b0;
    tick();
    n_checks++;
    if ({led, busy, done, cmd_ready} !== {4'h0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_release: led=%h busy=%b done=%b rdy=%b, required 0 0 0 1",
               led, busy, done, cmd_ready);
    end
    model_clear();
  endtask

  task automatic test_basic_loop();
    issue(2'b00, 3'd0, 4'b0001, 8'd2);
    issue(2'b00, 3'd1, 4'b0010, 8'd1);
    issue(2'b01, 3'd1, 4'h0, 8'd2);
    model_play(1, 2);
    n_checks++;
    if (busy !== 1'b1 || cmd_ready !== 1'b0 || exp_led.size() != 24) begin
      n_fail++;
      $display("FAIL basic_entry: busy=%b rdy=%b trace=%0d, required 1 0 24", busy, cmd_ready, exp_led.size());
    end
    for (int i = 0; i < exp_led.size(); i++) begin
      n_checks++;
      if (led !== exp_led[i] || step !== exp_step[i] || done !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_play[%0d]: led=%h step=%0d done=%b, required %h %0d 0",
                 i, led, step, done, exp_led[i], exp_step[i]);
      end
      tick();
    end
    n_checks++;
    if ({led, done, busy, cmd_ready} !== {4'h0, 1'b1, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL basic_done: led=%h done=%b busy=%b rdy=%b, required 0 1 0 1", led, done, busy, cmd_ready);
    end
    tick();
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done_pulse: done=%b, required 0", done);
    end
  endtask

  task automatic test_zero_duration();
    issue(2'b00, 3'd0, 4'b1111, 8'd0);
    issue(2'b01, 3'd0, 4'h0, 8'd3);
    model_play(0, 3);
    for (int i = 0; i < exp_led.size(); i++) begin
      n_checks++;
      if (led !== 4'b1111 || step !== 3'd0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL zero_dur[%0d]: led=%h step=%0d busy=%b, required f 0 1", i, led, step, busy);
      end
      tick();
    end
    n_checks++;
    if ({led, done, busy} !== {4'h0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL zero_dur_done: led=%h done=%b busy=%b, required 0 1 0", led, done, busy);
    end
    tick();
  endtask

  task automatic test_stop_boundary();
    issue(2'b00, 3'd0, 4'b0011, 8'd1);
    issue(2'b00, 3'd1, 4'b1100, 8'd2);
    issue(2'b01, 3'd1, 4'h0, 8'd0);
    model_play(1, 2);
    // index 16 is where step 0 of the second pass hands over to step 1
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (led !== exp_led[i] || step !== exp_step[i]) begin
        n_fail++;
        $display("FAIL stop_play[%0d]: led=%h step=%0d, required %h %0d", i, led, step, exp_led[i], exp_step[i]);
      end
      if (i == 15) stop = 1'b1;
      tick();
    end
    stop = 1'b0;
    n_checks++;
    if ({led, busy, done, cmd_ready, step} !== {4'h0, 1'b0, 1'b0, 1'b1, 3'd0}) begin
      n_fail++;
      $display("FAIL stop_boundary: led=%h busy=%b done=%b rdy=%b step=%0d, required 0 0 0 1 0",
               led, busy, done, cmd_ready, step);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (done !== 1'b0 || led !== 4'h0) begin
        n_fail++;
        $display("FAIL stop_quiet[%0d]: done=%b led=%h, required 0 0", i, done, led);
      end
    end
  endtask

  task automatic test_infinite_stall();
    issue(2'b00, 3'd0, 4'b0101, 8'd1);
    issue(2'b00, 3'd1, 4'b1010, 8'd1);
    issue(2'b01, 3'd1, 4'h0, 8'd0);
    model_play(1, 10);
    cmd_valid   = 1'b1;
    cmd_op      = 2'b00;
    cmd_addr    = 3'd0;
    cmd_pattern = 4'b1001;
    cmd_arg     = 8'd3;
    for (int i = 0; i < exp_led.size(); i++) begin
      n_checks++;
      if (led !== exp_led[i] || busy !== 1'b1 || cmd_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_play[%0d]: led=%h busy=%b rdy=%b, required %h 1 0",
                 i, led, busy, cmd_ready, exp_led[i]);
      end
      tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_checks++;
    if ({busy, cmd_ready, led} !== {1'b0, 1'b1, 4'h0}) begin
      n_fail++;
      $display("FAIL stall_stop: busy=%b rdy=%b led=%h, required 0 1 0", busy, cmd_ready, led);
    end
    tick();
    cmd_valid = 1'b0;
    m_pat[0] = 4'b1001;
    m_dur[0] = 8'd3;
    issue(2'b01, 3'd1, 4'h0, 8'd1);
    model_play(1, 1);
    for (int i = 0; i < exp_led.size(); i++) begin
      n_checks++;
      if (led !== exp_led[i] || step !== exp_step[i]) begin
        n_fail++;
        $display("FAIL stall_written[%0d]: led=%h step=%0d, required %h %0d",
                 i, led, step, exp_led[i], exp_step[i]);
      end
      tick();
    end
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_written_done: done=%b, required 1", done);
    end
    tick();
  endtask

  task automatic test_reset_midrun();
    issue(2'b00, 3'd0, 4'b0110, 8'd1);
    issue(2'b00, 3'd1, 4'b1011, 8'd2);
    issue(2'b00, 3'd2, 4'b0111, 8'd1);
    issue(2'b01, 3'd2, 4'h0, 8'd1);
    for (int i = 0; i < 6; i++) tick();
    n_checks++;
    if (led !== 4'b1011 || step !== 3'd1) begin
      n_fail++;
      $display("FAIL midrun_pre: led=%h step=%0d, required b 1", led, step);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({led, busy, done, cmd_ready, step} !== {4'h0, 1'b0, 1'b0, 1'b1, 3'd0}) begin
      n_fail++;
      $display("FAIL midrun_async: led=%h busy=%b done=%b rdy=%b step=%0d, required 0 0 0 1 0",
               led, busy, done, cmd_ready, step);
    end
    tick();
    rst = 1'b0;
    model_clear();
    issue(2'b01, 3'd2, 4'h0, 8'd1);
    model_play(2, 1);
    for (int i = 0; i < exp_led.size(); i++) begin
      n_checks++;
      if (led !== 4'h0 || step !== exp_step[i] || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL midrun_blank[%0d]: led=%h step=%0d busy=%b, required 0 %0d 1",
                 i, led, step, busy, exp_step[i]);
      end
      tick();
    end
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_done: done=%b busy=%b, required 1 0", done, busy);
    end
    tick();
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int nw, last, loops;
      nw = $urandom_range(1, 8);
      for (int w = 0; w < nw; w++)
        issue(2'b00, 3'($urandom_range(0, 7)), 4'($urandom), 8'($urandom_range(0, 3)));
      issue(2'($urandom_range(2, 3)), 3'($urandom), 4'($urandom), 8'($urandom));
      last  = $urandom_range(0, 7);
      loops = $urandom_range(1, 3);
      issue(2'b01, 3'(last), 4'h0, 8'(loops));
      model_play(last, loops);
      for (int i = 0; i < exp_led.size(); i++) begin
        n_checks++;
        if (led !== exp_led[i] || step !== exp_step[i] || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL rand%0d[%0d]: led=%h step=%0d busy=%b, required %h %0d 1",
                   it, i, led, step, busy, exp_led[i], exp_step[i]);
        end
        tick();
      end
      n_checks++;
      if ({led, done, busy} !== {4'h0, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL rand%0d_done: led=%h done=%b busy=%b, required 0 1 0", it, led, done, busy);
      end
      tick();
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic_loop();
    test_zero_duration();
    test_stop_boundary();
    test_infinite_stall();
    test_reset_midrun();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/led_sequencer.md
# led_sequencer

Programmable blink-pattern controller for the board LED bank. It replaces the fixed divide-by-50,000,000 toggle counter with a scheduler that drives a sequence of up to 8 LED patterns. Each step holds for a programmed number of prescaled ticks, and the sequence repeats a programmed number of loops. A host FSM or a debug UART bridge loads the steps and starts or stops playback through a valid/ready command port.

## Interface
- NUM_LEDS, 4, width of the LED bank.
- PRESCALE, 5_000_000, clk cycles per tick (100 ms at 50 MHz). Legal range is 1 to 2^32-1.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high on a rising clk edge.
- cmd_op  in  2  command opcode:
  - 00 WRITE: write one step.
  - 01 START: begin playback.
  - 10, 11: reserved, accepted as no-ops.
- cmd_addr  in  3  WRITE: step index. START: index of the last step.
- cmd_pattern  in  NUM_LEDS  WRITE: LED value for the step.
- cmd_arg  in  8  WRITE: step duration in ticks. START: loop count, 0 = infinite.
- stop  in  1  abort playback. Sampled every cycle; ignored in IDLE.
- led  out  NUM_LEDS  registered LED drive.
- busy  out  1  high in RUN.
- step  out  3  index of the step currently displayed.
- done  out  1  one-cycle pulse when playback completes its loop count.

## Operation
- Step memory: 8 entries of {pattern, dur[7:0]}. Reset clears every entry to 0.
- States: IDLE and RUN.
- cmd_ready = (state == IDLE), registered-state based only.
  - Commands presented in RUN stall and are not lost.
  - The command stays pending until the sequencer returns to IDLE.
- IDLE behaviour:
  - WRITE sets mem[cmd_addr] <= {cmd_pattern, cmd_arg}.
  - START latches last <= cmd_addr and loops_left <= cmd_arg, sets infinite = (cmd_arg == 0), then enters RUN at step 0.
- RUN entry and per-step display:
  - led <= mem[step].pattern.
  - Prescaler counts 0..PRESCALE-1 and produces a tick on its terminal count.
  - Tick counter counts ticks within the step.
- Effective step duration is max(dur, 1) ticks; dur = 0 is treated as 1.
- End of step:
  - If step != last: step <= step+1, next pattern loads, prescaler and tick counter clear.
  - If step == last and infinite: step <= 0.
  - If step == last and not infinite: loops_left decrements. If loops_left was 1, go to IDLE with led <= 0 and done = 1 for one cycle. Otherwise step <= 0.
- stop high in RUN:
  - Next state is IDLE, led <= 0, step <= 0, no done pulse.
  - stop wins over a step or loop boundary in the same cycle.
- A last value beyond the written entries is legal; unwritten entries play as pattern 0, dur 0.
- Memory is never modified during RUN.
- Counter widths:
  - Prescaler is 32 bits and compares against PRESCALE-1.
  - Tick counter is 8 bits and never wraps, because it clears at dur-1.
  - loops_left is 8 bits.

## Timing
- Reset values: led = 0, busy = 0, step = 0, done = 0, cmd_ready = 1, state = IDLE, all counters 0.
- Reset mid-RUN returns everything to these values immediately (asynchronous) and clears the memory.
- START accepted on edge T:
  - At T+1: busy = 1, led = mem[0].pattern, step = 0, cmd_ready = 0.
- Each step is displayed for exactly max(dur, 1) × PRESCALE cycles.
- The next pattern appears on the edge after the final prescaler count of the step, with no dead cycle between steps.
- Completion:
  - On the first IDLE cycle: led = 0, busy = 0, cmd_ready = 1, done = 1.
  - done falls on the following cycle.
- stop high sampled on edge S in RUN: at S+1, IDLE, led = 0, busy = 0.
- A WRITE accepted on edge T is visible to a START accepted on edge T+1.

## Test plan
- Reset: assert rst asynchronously between edges -> led = 0, busy = 0, done = 0, cmd_ready = 1 immediately, held until after release.
- Basic loop (PRESCALE = 4):
  - Stimulus: WRITE 0 = {0001, 2}, WRITE 1 = {0010, 1}, START last = 1 loops = 2.
  - Response: led = 0001 for 8 cycles, then 0010 for 4, then 0001 for 8, then 0010 for 4.
  - Then at start+25: led = 0, done = 1 for exactly 1 cycle, busy = 0.
- Zero duration (PRESCALE = 4):
  - Stimulus: WRITE 0 = {1111, 0}, START last = 0 loops = 3.
  - Response: led = 1111 for 12 cycles total, step stays 0, then done.
- Stop at boundary:
  - Stimulus: infinite playback; assert stop on the exact cycle of a step transition.
  - Response: next cycle IDLE, led = 0, no done, no pattern change seen.
- Infinite and stall:
  - Stimulus: loops = 0 for 10+ loops, with a WRITE held valid throughout RUN.
  - Response: busy stays 1, cmd_ready stays 0, memory is unchanged. After stop, the WRITE is accepted on the first IDLE cycle.
- Reset mid-run: assert rst during step 1 -> outputs return to reset values; a following START with unwritten memory plays led = 0 for PRESCALE cycles per step.
